// File: rtl/softmax_seq_pkg.sv
// Shared types for the softmax job sequencer.
// FSM encoding and the queued job record.
package softmax_seq_pkg;

    localparam int JOB_AW = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_GAP    = 3'd2,
        S_START  = 3'd3,
        S_RUN    = 3'd4,
        S_REPORT = 3'd5
    } state_t;

    typedef struct packed {
        logic [JOB_AW-1:0] start_addr;
        logic [JOB_AW-1:0] end_addr;
    } job_t;

endpackage

// File: rtl/softmax_job_seq_if.sv
// Job request channel: valid/ready push of address pairs,
// with the reject pulse returned to the requester.
interface softmax_job_seq_if #(
    parameter int ADDRSIZE = 8
);
    logic                job_valid;
    logic                job_ready;
    logic [ADDRSIZE-1:0] job_start_addr;
    logic [ADDRSIZE-1:0] job_end_addr;
    logic                bad_job;

    modport master (
        output job_valid,
        output job_start_addr,
        output job_end_addr,
        input  job_ready,
        input  bad_job
    );

    modport slave (
        input  job_valid,
        input  job_start_addr,
        input  job_end_addr,
        output job_ready,
        output bad_job
    );
endinterface

// File: rtl/softmax_job_fifo.sv
// Generic synchronous FIFO with registered occupancy.
// DEPTH must be a power of two; pointers wrap naturally.
module softmax_job_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

// File: rtl/softmax_job_seq.sv
// Softmax job sequencer: pops queued jobs and runs the core's
// init/start/done handshake, reporting cycles and timeout per job.
module softmax_job_seq
    import softmax_seq_pkg::*;
#(
    parameter int ADDRSIZE    = JOB_AW,
    parameter int FIFO_DEPTH  = 4,
    parameter int INIT_CYCLES = 2,
    parameter int TIMEOUT     = 4096,
    parameter int CNTW        = 16
) (
    input  logic                clk,
    input  logic                reset,
    softmax_job_seq_if.slave    jif,
    output logic                sm_init,
    output logic                sm_start,
    output logic [ADDRSIZE-1:0] sm_start_addr,
    output logic [ADDRSIZE-1:0] sm_end_addr,
    input  logic                sm_done,
    output logic                busy,
    output logic                res_valid,
    output logic [CNTW-1:0]     res_cycles,
    output logic                res_timeout,
    output logic [CNTW-1:0]     jobs_done
);
    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNTW-1:0] TMAX = CNTW'(TIMEOUT - 1);

    state_t          state;
    state_t          state_d;
    logic [CNTW-1:0] cnt;
    logic [IW-1:0]   init_cnt;
    logic            accept;
    logic            is_bad;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic            bad_q;
    job_t            job_in;
    job_t            head;

    assign accept  = jif.job_valid && jif.job_ready;
    assign is_bad  = jif.job_end_addr < jif.job_start_addr;
    assign push    = accept && !is_bad;
    assign pop     = (state == S_IDLE) && !empty;
    assign busy    = (state != S_IDLE) || !empty;
    assign jif.job_ready = !full;
    assign jif.bad_job   = bad_q;

    assign job_in.start_addr = JOB_AW'(jif.job_start_addr);
    assign job_in.end_addr   = JOB_AW'(jif.job_end_addr);

    softmax_job_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(job_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (job_in),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    // Done outranks timeout when both land in the same RUN cycle.
    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:   if (!empty) state_d = S_INIT;
            S_INIT:   if (init_cnt == IW'(INIT_CYCLES - 1)) state_d = S_GAP;
            S_GAP:    state_d = S_START;
            S_START:  state_d = S_RUN;
            S_RUN:    if (sm_done || cnt == TMAX) state_d = S_REPORT;
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sm_init       <= 1'b1;
            sm_start      <= 1'b0;
            sm_start_addr <= '0;
            sm_end_addr   <= '0;
            res_valid     <= 1'b0;
            res_cycles    <= '0;
            res_timeout   <= 1'b0;
            jobs_done     <= '0;
            bad_q         <= 1'b0;
            cnt           <= '0;
            init_cnt      <= '0;
        end else begin
            sm_init   <= (state_d == S_INIT);
            sm_start  <= (state_d == S_START);
            res_valid <= (state_d == S_REPORT);
            bad_q     <= accept && is_bad;
            init_cnt  <= (state == S_INIT) ? init_cnt + 1'b1 : '0;
            if (pop) begin
                sm_start_addr <= ADDRSIZE'(head.start_addr);
                sm_end_addr   <= ADDRSIZE'(head.end_addr);
            end
            if (state == S_START)    cnt <= '0;
            else if (state == S_RUN) cnt <= cnt + 1'b1;
            if (state == S_RUN && state_d == S_REPORT) begin
                res_cycles  <= cnt;
                res_timeout <= !sm_done;
            end
            if (state_d == S_REPORT) jobs_done <= jobs_done + 1'b1;
        end
    end
endmodule

// File: tb/tb_softmax_job_seq.sv
// Self-checking bench for softmax_job_seq with a behavioural
// softmax core model and an in-order result scoreboard.
`timescale 1ns/1ps
module tb_softmax_job_seq;
    localparam int AW = 8;
    localparam int CW = 16;

    typedef struct {
        logic [AW-1:0] s;
        logic [AW-1:0] e;
        int            dly;
        bit            noisy;
        int            ecyc;
        bit            eto;
    } vec_t;

    typedef struct {
        logic [AW-1:0] s;
        logic [AW-1:0] e;
        int            ecyc;
        bit            eto;
    } exp_t;

    typedef struct {
        int dly;
        bit noisy;
    } mdl_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sm_init;
    logic          sm_start;
    logic          sm_done = 1'b0;
    logic          busy;
    logic          res_valid;
    logic          res_timeout;
    logic [AW-1:0] sm_start_addr;
    logic [AW-1:0] sm_end_addr;
    logic [CW-1:0] res_cycles;
    logic [CW-1:0] jobs_done;

    softmax_job_seq_if #(.ADDRSIZE(AW)) jif();

    softmax_job_seq #(
        .ADDRSIZE    (AW),
        .FIFO_DEPTH  (4),
        .INIT_CYCLES (2),
        .TIMEOUT     (64),
        .CNTW        (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .jif           (jif),
        .sm_init       (sm_init),
        .sm_start      (sm_start),
        .sm_start_addr (sm_start_addr),
        .sm_end_addr   (sm_end_addr),
        .sm_done       (sm_done),
        .busy          (busy),
        .res_valid     (res_valid),
        .res_cycles    (res_cycles),
        .res_timeout   (res_timeout),
        .jobs_done     (jobs_done)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   exp_done = 0;
    int   bad_exp = 0;
    int   bad_seen = 0;
    exp_t exp_q[$];
    mdl_t mdl_q[$];
    vec_t vec[15];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Core model: done k cycles after start, sticky until next init.
    int   k = 0;
    bit   active = 0;
    mdl_t cur;
    always @(negedge clk) begin
        if (reset) begin
            sm_done = 1'b0;
            active  = 0;
        end else if (sm_start) begin
            if (mdl_q.size() > 0) cur = mdl_q.pop_front();
            else cur = '{0, 1'b0};
            active  = 1;
            k       = 0;
            sm_done = cur.noisy;
        end else if (active) begin
            k++;
            if (cur.dly != 0 && k == cur.dly) begin
                sm_done = 1'b1;
                active  = 0;
            end else begin
                sm_done = 1'b0;
            end
        end else if (sm_init) begin
            sm_done = (mdl_q.size() > 0) && mdl_q[0].noisy;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (jif.bad_job) bad_seen++;
            if (sm_start) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL start_unexpected: got 1 want 0");
                end else begin
                    chk("start_addr", sm_start_addr, exp_q[0].s);
                    chk("end_addr", sm_end_addr, exp_q[0].e);
                end
            end
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL res_unexpected: got 1 want 0");
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    exp_done++;
                    chk("res_cycles", res_cycles, x.ecyc);
                    chk("res_timeout", res_timeout, x.eto);
                    chk("jobs_done", jobs_done, exp_done);
                end
            end
        end
    end

    task automatic push_job(input vec_t v);
        int n = 0;
        jif.job_valid      = 1'b1;
        jif.job_start_addr = v.s;
        jif.job_end_addr   = v.e;
        while (!jif.job_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!jif.job_ready) begin
            checks++;
            errors++;
            $display("FAIL push_wait: got 0 want 1");
        end else if (v.e >= v.s) begin
            exp_q.push_back('{v.s, v.e, v.ecyc, v.eto});
            mdl_q.push_back('{v.dly, v.noisy});
        end else begin
            bad_exp++;
        end
        @(negedge clk);
        jif.job_valid = 1'b0;
        if (v.e < v.s) chk("bad_job_pulse", jif.bad_job, 1);
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", (exp_q.size() == 0 && !busy), 1);
    endtask

    initial begin
        bit ip[6];
        bit sp[6];
        int n;
        ip = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        sp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[0]  = '{8'h00, 8'h0F, 37, 1'b0, 36, 1'b0};
        vec[1]  = '{8'h01, 8'h02, 20, 1'b0, 19, 1'b0};
        vec[2]  = '{8'h03, 8'h03,  5, 1'b0,  4, 1'b0};
        vec[3]  = '{8'h04, 8'h08,  1, 1'b0,  0, 1'b0};
        vec[4]  = '{8'h09, 8'h0A, 10, 1'b0,  9, 1'b0};
        vec[5]  = '{8'h0B, 8'h0C, 64, 1'b0, 63, 1'b0};
        vec[6]  = '{8'h10, 8'h10,  2, 1'b0,  1, 1'b0};
        vec[7]  = '{8'h20, 8'h21,  0, 1'b0, 63, 1'b1};
        vec[8]  = '{8'h22, 8'h23,  3, 1'b0,  2, 1'b0};
        vec[9]  = '{8'h30, 8'h31,  4, 1'b0,  3, 1'b0};
        vec[10] = '{8'h32, 8'h33,  6, 1'b1,  5, 1'b0};
        vec[11] = '{8'h40, 8'h41,  0, 1'b0, 63, 1'b1};
        vec[12] = '{8'h42, 8'h43,  5, 1'b0,  4, 1'b0};
        vec[13] = '{8'h44, 8'h45,  5, 1'b0,  4, 1'b0};
        vec[14] = '{8'h50, 8'h5F,  9, 1'b0,  8, 1'b0};

        jif.job_valid      = 1'b0;
        jif.job_start_addr = '0;
        jif.job_end_addr   = '0;
        repeat (2) @(negedge clk);
        chk("rst_sm_init", sm_init, 1);
        chk("rst_sm_start", sm_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_job_ready", jif.job_ready, 1);
        chk("rst_jobs_done", jobs_done, 0);
        chk("rst_bad_job", jif.bad_job, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_sm_init", sm_init, 0);

        push_job(vec[0]);
        for (int i = 0; i < 6; i++) begin
            chk("init_seq", sm_init, ip[i]);
            chk("start_seq", sm_start, sp[i]);
            @(negedge clk);
        end
        wait_idle(500);

        for (int i = 1; i <= 5; i++) push_job(vec[i]);
        chk("ready_full", jif.job_ready, 0);
        chk("busy_full", busy, 1);
        wait_idle(2000);

        push_job('{8'h10, 8'h0F, 0, 1'b0, 0, 1'b0});
        push_job(vec[6]);
        wait_idle(500);

        for (int i = 7; i <= 10; i++) push_job(vec[i]);
        wait_idle(1000);
        chk("jobs_done_mid", jobs_done, 11);

        for (int i = 11; i <= 13; i++) push_job(vec[i]);
        n = 0;
        while (!sm_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_run_start_seen", sm_start, 1);
        repeat (5) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("arst_sm_init", sm_init, 1);
        chk("arst_sm_start", sm_start, 0);
        chk("arst_res_valid", res_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_job_ready", jif.job_ready, 1);
        chk("arst_jobs_done", jobs_done, 0);
        exp_q.delete();
        mdl_q.delete();
        exp_done = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        push_job(vec[14]);
        wait_idle(500);
        chk("jobs_done_final", jobs_done, 1);
        chk("bad_count", bad_seen, bad_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/softmax_job_seq.md
Name: softmax_job_seq

Overview:
Job sequencer that drives the softmax core's init/start/done handshake from a queue of (start_addr, end_addr) jobs. Requesters push jobs into a small internal FIFO. The sequencer pops one job at a time, initialises the core, pulses start and waits for done or a timeout. Per job it reports cycle count and status. It sits between the host/control logic and the softmax top-level, replacing hand-driven init/start sequencing.

Parameters:
ADDRSIZE, 8, width of softmax start/end address
FIFO_DEPTH, 4, job queue depth; power of 2, >=2
INIT_CYCLES, 2, cycles sm_init is held high per job; >=1
TIMEOUT, 4096, max RUN cycles before the job is aborted; <2^CNTW
CNTW, 16, width of cycle and job counters

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  asynchronous, active-high reset
job_valid  in  1  job request valid
job_ready  out  1  queue can accept a job
job_start_addr  in  ADDRSIZE  first vector address of job
job_end_addr  in  ADDRSIZE  last vector address of job
bad_job  out  1  1-cycle pulse: accepted job rejected (end<start)
sm_init  out  1  to softmax init
sm_start  out  1  to softmax start
sm_start_addr  out  ADDRSIZE  to softmax start_addr, held stable during job
sm_end_addr  out  ADDRSIZE  to softmax end_addr, held stable during job
sm_done  in  1  from softmax done
busy  out  1  FSM not in IDLE, or FIFO non-empty
res_valid  out  1  1-cycle pulse: job finished
res_cycles  out  CNTW  RUN cycles of finished job, valid with res_valid
res_timeout  out  1  finished job hit TIMEOUT, valid with res_valid
jobs_done  out  CNTW  count of res_valid pulses, wraps at 2^CNTW

Behaviour:
- Reset values:
  - sm_init=1; all other outputs 0; FIFO empty; FSM=IDLE.
  - sm_init is combinationally 1 while reset is high.
- FIFO:
  - job_ready = !full, from registered occupancy.
  - Accept occurs on job_valid && job_ready.
  - An accepted job with end_addr<start_addr is not enqueued; bad_job pulses the next cycle.
  - end_addr==start_addr is a legal 1-vector job.
  - Simultaneous push and pop allowed at any occupancy except push-when-full (blocked by job_ready).
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states IDLE, INIT, GAP, START, RUN, REPORT:
  - IDLE: sm_init=0. If FIFO non-empty: pop head, register addresses into sm_start_addr/sm_end_addr, go INIT. A job pushed into an empty FIFO is popped no earlier than the cycle after acceptance.
  - INIT: sm_init=1 for exactly INIT_CYCLES cycles, then GAP.
  - GAP: 1 cycle, sm_init=0, sm_start=0, then START.
  - START: sm_start=1 for exactly 1 cycle; cycle counter cleared to 0; go RUN.
  - RUN: counter increments by 1 per cycle; sm_done is sampled only here.
    - sm_done=1 → REPORT with res_cycles=counter value that cycle (first RUN cycle = 0), res_timeout=0.
    - Else if counter==TIMEOUT-1 → REPORT with res_cycles=TIMEOUT-1, res_timeout=1.
    - done and timeout in the same cycle: done wins.
  - REPORT: res_valid=1 for 1 cycle; jobs_done+=1; go IDLE.
- sm_done asserted outside RUN is ignored. A sticky done from the previous job is cleared by the next job's INIT.
- sm_start_addr/sm_end_addr change only on pop and hold until the next pop.
- Back-to-back jobs: REPORT → IDLE → INIT. Minimum overhead is INIT_CYCLES+4 cycles between a done and the next sm_start.
- Reset mid-job: immediate abort, no res_valid. Queued jobs are lost.
- Outputs are registered, except job_ready and busy, which are decoded from registers.

Decomposition:
- Shared package softmax_seq_pkg holds:
  - the FSM state enum (3-bit encoding);
  - the job record typedef {start_addr, end_addr}.
- Sub-module softmax_job_fifo (generic synchronous FIFO, DEPTH/WIDTH params, full/empty, async active-high reset) is natural. The FSM and counters stay in softmax_job_seq.

Test Plan:
- Reset then single job (0x00,0x0F); model asserts sm_done 37 cycles after sm_start → sm_init high 2 cycles, GAP, sm_start 1 cycle; res_valid with res_cycles=36, res_timeout=0, jobs_done=1; sm_init=1 throughout reset.
- Push 5 jobs back-to-back with FIFO_DEPTH=4 while the first is running → job_ready drops with 4 queued; all 5 complete in push order with matching sm_start_addr; jobs_done=5.
- Job (0x10,0x0F) → bad_job pulse, no sm_start, jobs_done unchanged; following job (0x10,0x10) runs normally.
- Model never asserts done, TIMEOUT=64 → res_valid 64 cycles after START with res_cycles=63, res_timeout=1; next queued job then runs.
- sm_done held high from previous job and asserted during INIT/START → ignored until RUN; no zero-cycle result.
- Reset asserted mid-RUN with 2 jobs queued → outputs return to reset values asynchronously, FIFO empty, no res_valid; after release, new job completes normally.
